// File: rtl/key_fetch.sv
// key_fetch: key-load client on the crypto AXI read arbiter's key port.
// A start command issues one burst request for KEY_BEATS beats. The returned
// beats are written into an internal key RAM and the burst is checked for
// completeness. The key is then served through a registered read port.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   start               1-cycle load command (ignored while busy)
//   key_base_addr       burst start address, sampled with an accepted start
//   busy                high while requesting / receiving
//   done                1-cycle pulse when a complete key has been stored
//   key_valid           RAM holds a complete, checked key
//   err, err_code       sticky load error: 1 early last, 2 missing last, 3 timeout
//   key_axi_rvalid      1-cycle request pulse to the arbiter
//   key_axi_raddr       request address, held until the next accepted start
//   key_axi_rd_*        returned beat stream (no backpressure)
//   key_rd_en/idx       key RAM read strobe and word index
//   key_rd_data/valid   read data and strobe, one cycle after key_rd_en
module key_fetch #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 512,
  parameter int KEY_IDX_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        start,
  input  logic [C_AXI_ADDR_WIDTH-1:0] key_base_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        key_valid,
  output logic                        err,
  output logic [1:0]                  err_code,
  output logic                        key_axi_rvalid,
  output logic [C_AXI_ADDR_WIDTH-1:0] key_axi_raddr,
  input  logic                        key_axi_rd_rvalid,
  input  logic [C_AXI_DATA_WIDTH-1:0] key_axi_rd_data,
  input  logic                        key_axi_rd_last,
  input  logic                        key_rd_en,
  input  logic [KEY_IDX_WIDTH-1:0]    key_rd_idx,
  output logic [C_AXI_DATA_WIDTH-1:0] key_rd_data,
  output logic                        key_rd_valid
);

  localparam int                       KEY_BEATS   = 2 ** KEY_IDX_WIDTH;
  localparam logic [KEY_IDX_WIDTH-1:0] LAST_IDX    = '1;
  localparam logic [15:0]              TIMER_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CODE_EARLY_LAST   = 2'd1;
  localparam logic [1:0] CODE_MISSING_LAST = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT      = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_DONE,
    S_ERR
  } state_t;

  state_t                      state;
  logic [KEY_IDX_WIDTH-1:0]    beat_cnt;
  logic [15:0]                 timer;
  logic [C_AXI_DATA_WIDTH-1:0] key_ram [KEY_BEATS];
  logic                        ram_we;

  // Beats are only accepted while receiving; anything else on the bus is dropped.
  assign ram_we = (state == S_RECV) && key_axi_rd_rvalid;

  // Load controller
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= S_IDLE;
      beat_cnt       <= '0;
      timer          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      key_valid      <= 1'b0;
      err            <= 1'b0;
      err_code       <= 2'd0;
      key_axi_rvalid <= 1'b0;
      key_axi_raddr  <= '0;
    end else begin
      done           <= 1'b0;
      key_axi_rvalid <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            // The arbiter samples the live address at grant time, so the
            // address register only changes on an accepted start.
            key_axi_raddr  <= key_base_addr;
            key_valid      <= 1'b0;
            err            <= 1'b0;
            err_code       <= 2'd0;
            beat_cnt       <= '0;
            timer          <= '0;
            key_axi_rvalid <= 1'b1;
            busy           <= 1'b1;
            state          <= S_REQ;
          end
        end
        S_REQ: begin
          state <= S_RECV;
        end
        S_RECV: begin
          if (key_axi_rd_rvalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            timer    <= '0;
            if (key_axi_rd_last) begin
              busy <= 1'b0;
              if (beat_cnt == LAST_IDX) begin
                state     <= S_DONE;
                key_valid <= 1'b1;
                done      <= 1'b1;
              end else begin
                state    <= S_ERR;
                err      <= 1'b1;
                err_code <= CODE_EARLY_LAST;
              end
            end else if (beat_cnt == LAST_IDX) begin
              busy     <= 1'b0;
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= CODE_MISSING_LAST;
            end
          end else if (timer == TIMER_LIMIT) begin
            busy     <= 1'b0;
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= CODE_TIMEOUT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Key RAM write side; contents survive reset.
  always_ff @(posedge aclk) begin
    if (ram_we) begin
      key_ram[beat_cnt] <= key_axi_rd_data;
    end
  end

  // Registered read port; a same-cycle write to the same word returns the old word.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      key_rd_valid <= 1'b0;
      key_rd_data  <= '0;
    end else begin
      key_rd_valid <= key_rd_en;
      if (key_rd_en) begin
        key_rd_data <= key_ram[key_rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_key_fetch.sv
module tb_key_fetch;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 8;
  localparam int NB = 256;
  localparam int TO = 100;

  logic          aclk = 1'b0;
  logic          areset;
  logic          start;
  logic [AW-1:0] key_base_addr;
  logic          busy;
  logic          done;
  logic          key_valid;
  logic          err;
  logic [1:0]    err_code;
  logic          key_axi_rvalid;
  logic [AW-1:0] key_axi_raddr;
  logic          key_axi_rd_rvalid;
  logic [DW-1:0] key_axi_rd_data;
  logic          key_axi_rd_last;
  logic          key_rd_en;
  logic [IW-1:0] key_rd_idx;
  logic [DW-1:0] key_rd_data;
  logic          key_rd_valid;

  key_fetch #(
    .C_AXI_ADDR_WIDTH(AW),
    .C_AXI_DATA_WIDTH(DW),
    .KEY_IDX_WIDTH   (IW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .start            (start),
    .key_base_addr    (key_base_addr),
    .busy             (busy),
    .done             (done),
    .key_valid        (key_valid),
    .err              (err),
    .err_code         (err_code),
    .key_axi_rvalid   (key_axi_rvalid),
    .key_axi_raddr    (key_axi_raddr),
    .key_axi_rd_rvalid(key_axi_rd_rvalid),
    .key_axi_rd_data  (key_axi_rd_data),
    .key_axi_rd_last  (key_axi_rd_last),
    .key_rd_en        (key_rd_en),
    .key_rd_idx       (key_rd_idx),
    .key_rd_data      (key_rd_data),
    .key_rd_valid     (key_rd_valid)
  );

  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  // Count of request pulses seen on the arbiter side.
  int rv_pulses = 0;
  always @(posedge aclk) if (key_axi_rvalid === 1'b1) rv_pulses++;

  // Reference model: transaction phase (0 idle/done/err, 1 request, 2 receiving)
  // plus the architectural outputs and the expected RAM image.
  logic [DW-1:0] m_ram [NB];
  int            m_phase, m_cnt, m_idle;
  bit            m_valid, m_err, m_done;
  logic [1:0]    m_code;
  logic [AW-1:0] m_addr;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] exp;
  } rd_vec_t;

  typedef struct {
    int         nbeats;
    int         last_pos;
    logic [1:0] code;
    bit         valid;
  } scn_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_idle = 0;
    m_valid = 0; m_err = 0; m_done = 0;
    m_code = 2'd0; m_addr = '0;
  endtask

  task automatic chk_all();
    chk("busy", busy, m_phase != 0);
    chk("rvalid", key_axi_rvalid, m_phase == 1);
    chk("done", done, m_done);
    chk("key_valid", key_valid, m_valid);
    chk("err", err, m_err);
    chk("err_code", err_code, m_code);
    chk("raddr", key_axi_raddr, m_addr);
  endtask

  // One clock cycle of stimulus, model update and full output comparison.
  task automatic cyc(input bit beat, input logic [DW-1:0] d, input bit lst,
                     input bit st, input logic [AW-1:0] addr, input bit rd_rand);
    bit            en;
    logic [IW-1:0] idx;
    logic [DW-1:0] exp_rd;
    en     = rd_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    idx    = IW'($urandom_range(0, NB - 1));
    exp_rd = m_ram[idx];
    key_rd_en         = en;
    key_rd_idx        = idx;
    key_axi_rd_rvalid = beat;
    key_axi_rd_data   = d;
    key_axi_rd_last   = lst;
    start             = st;
    key_base_addr     = addr;
    step();
    key_axi_rd_rvalid = 1'b0;
    key_axi_rd_last   = 1'b0;
    start             = 1'b0;
    key_rd_en         = 1'b0;
    m_done = 0;
    if (st && m_phase == 0) begin
      m_phase = 1; m_addr = addr; m_valid = 0; m_err = 0; m_code = 2'd0; m_cnt = 0;
    end else if (m_phase == 1) begin
      m_phase = 2; m_idle = 0;
    end else if (m_phase == 2) begin
      if (beat) begin
        m_ram[m_cnt] = d;
        m_cnt++;
        m_idle = 0;
        if (lst || m_cnt == NB) begin
          m_phase = 0;
          if (lst && m_cnt == NB) begin
            m_valid = 1; m_done = 1;
          end else begin
            m_err = 1; m_code = lst ? 2'd1 : 2'd2;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_phase = 0; m_err = 1; m_code = 2'd3;
        end
      end
    end
    chk_all();
    chk("rd_valid", key_rd_valid, en);
    if (en) chk("rd_data", key_rd_data, exp_rd);
  endtask

  task automatic rd_chk(input logic [IW-1:0] idx, input logic [DW-1:0] exp);
    key_rd_en  = 1'b1;
    key_rd_idx = idx;
    step();
    key_rd_en = 1'b0;
    chk("rd_valid_tbl", key_rd_valid, 1'b1);
    chk("rd_data_tbl", key_rd_data, exp);
  endtask

  task automatic load(input logic [AW-1:0] addr, input int nbeats, input int last_pos,
                      input int max_gap, input bit rd_rand, input bit rand_data,
                      input int ign_at);
    logic [DW-1:0] d;
    int            gap;
    cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0, 1'b1, addr, rd_rand);
    cyc(1'b0, '0, 1'b0, 1'b0, addr, rd_rand);
    for (int i = 0; i < nbeats; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) cyc(1'b0, '0, 1'b0, 1'b0, addr, rd_rand);
      d = rand_data ? {$urandom, $urandom} : DW'(i);
      cyc(1'b1, d, i == last_pos, i == ign_at, ~addr, rd_rand);
    end
  endtask

  rd_vec_t       rd_tbl  [5];
  scn_t          scn_tbl [5];
  int            rv_before;
  logic [AW-1:0] a;

  initial begin
    rd_tbl[0] = '{8'd0,   64'd0};
    rd_tbl[1] = '{8'd128, 64'd128};
    rd_tbl[2] = '{8'd255, 64'd255};
    rd_tbl[3] = '{8'd1,   64'd1};
    rd_tbl[4] = '{8'd77,  64'd77};
    // nbeats, last position (-1 none), expected err_code, expected key_valid
    scn_tbl[0] = '{256, 255, 2'd0, 1'b1};
    scn_tbl[1] = '{120,  99, 2'd1, 1'b0};
    scn_tbl[2] = '{256,  -1, 2'd2, 1'b0};
    scn_tbl[3] = '{256,   0, 2'd1, 1'b0};
    scn_tbl[4] = '{256, 255, 2'd0, 1'b1};

    areset = 1'b1; start = 1'b0; key_base_addr = '0;
    key_axi_rd_rvalid = 1'b0; key_axi_rd_data = '0; key_axi_rd_last = 1'b0;
    key_rd_en = 1'b0; key_rd_idx = '0;
    model_reset();
    step(); step(); step();

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_code", err_code, 2'd0);
    chk("rst_rvalid", key_axi_rvalid, 1'b0);
    chk("rst_raddr", key_axi_raddr, 32'd0);
    chk("rst_rd_valid", key_rd_valid, 1'b0);
    chk("rst_rd_data", key_rd_data, 64'd0);
    areset = 1'b0;
    step();

    // Full load with data = beat index, back-to-back beats
    rv_before = rv_pulses;
    load(32'h1000_0000, NB, NB - 1, 0, 1'b0, 1'b0, -1);
    chk("t1_rv_pulses", rv_pulses - rv_before, 1);
    for (int i = 0; i < 5; i++) rd_chk(rd_tbl[i].idx, rd_tbl[i].exp);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    // Scenario table: random data, random gaps, interleaved reads, stray beats
    for (int s = 0; s < 5; s++) begin
      a = $urandom;
      rv_before = rv_pulses;
      load(a, scn_tbl[s].nbeats, scn_tbl[s].last_pos, 20, 1'b1, 1'b1, (s == 0) ? 10 : -1);
      chk("scn_code", err_code, scn_tbl[s].code);
      chk("scn_valid", key_valid, scn_tbl[s].valid);
      chk("scn_err", err, scn_tbl[s].code != 2'd0);
      chk("scn_raddr", key_axi_raddr, a);
      chk("scn_rv_pulses", rv_pulses - rv_before, 1);
      for (int k = 0; k < 3; k++) cyc(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, a, 1'b1);
      rd_chk('0, m_ram[0]);
    end

    // Timeout: beats with gaps just below the limit, then silence
    a = 32'hCAFE_0040;
    cyc(1'b0, '0, 1'b0, 1'b1, a, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, a, 1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < TO - 10; g++) cyc(1'b0, '0, 1'b0, 1'b0, a, 1'b1);
      cyc(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, a, 1'b1);
    end
    for (int g = 0; g < TO - 1; g++) cyc(1'b0, '0, 1'b0, 1'b0, a, 1'b1);
    chk("to_not_yet", err, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, a, 1'b1);
    chk("to_err", err, 1'b1);
    chk("to_code", err_code, 2'd3);

    // Asynchronous reset after 50 beats; the rest of the burst is dropped
    a = 32'h2000_0100;
    cyc(1'b0, '0, 1'b0, 1'b1, a, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, a, 1'b0);
    for (int i = 0; i < 50; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, a, 1'b1);
    areset = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_rvalid", key_axi_rvalid, 1'b0);
    chk("arst_raddr", key_axi_raddr, 32'd0);
    chk("arst_err", err, 1'b0);
    chk("arst_key_valid", key_valid, 1'b0);
    chk("arst_done", done, 1'b0);
    model_reset();
    step(); step();
    areset = 1'b0;
    for (int i = 50; i < NB; i++)
      cyc(1'b1, {$urandom, $urandom}, i == NB - 1, 1'b0, a, 1'b1);
    rd_chk(8'd49, m_ram[49]);
    rd_chk(8'd50, m_ram[50]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
